// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO status type and parameter helpers
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } fifo_status_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port storage, sync write, async read
// Deliberately unreset so tools can map it onto RAM/MLAB primitives.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised FWFT synchronous FIFO with flush and sticky error flags
// Pointers carry an extra wrap bit so full/empty fall out of a pointer compare.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              w_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              r_en,
  output logic [DATA_W-1:0] out_data,
  output logic              q_full,
  output logic              q_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   contain_num,
  output logic              ovf,
  output logic              udf,
  input  logic              clr_err
);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT = AE_LEVEL[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            wr_acc, rd_acc, mem_we;
  fifo_status_t    st;

  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    st.empty  = (wr_ptr_q == rd_ptr_q);
    st.full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    st.afull  = (count >= AF_CNT);
    st.aempty = (count <= AE_CNT);
    st.ovf    = ovf_q;
    st.udf    = udf_q;
  end

  // A pop frees a slot this edge, so a full FIFO still accepts a write paired with a read.
  always_comb begin
    rd_acc   = r_en & ~st.empty;
    wr_acc   = w_en & (~st.full | r_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (clr_err) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (w_en & st.full & ~r_en) ovf_d = 1'b1;
      if (r_en & st.empty)        udf_d = 1'b1;
    end
    mem_we = wr_acc & ~flush & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (out_data)
  );

  assign q_full       = st.full;
  assign q_empty      = st.empty;
  assign almost_full  = st.afull;
  assign almost_empty = st.aempty;
  assign contain_num  = count;
  assign ovf          = st.ovf;
  assign udf          = st.udf;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - self-checking bench for fifo_param against a queue model
module tb_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 1;

  logic             clk = 1'b0;
  logic             rst, flush, w_en, r_en, clr_err;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic             q_full, q_empty, almost_full, almost_empty, ovf, udf;
  logic [3:0]       contain_num;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model_q[$];
  bit                m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .w_en         (w_en),
    .in_data      (in_data),
    .r_en         (r_en),
    .out_data     (out_data),
    .q_full       (q_full),
    .q_empty      (q_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .contain_num  (contain_num),
    .ovf          (ovf),
    .udf          (udf),
    .clr_err      (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model advances on the clock edge from the rules: what is accepted depends only on occupancy.
  task automatic model_edge();
    int  n;
    bit  full, empty;
    if (rst) begin
      model_q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else if (flush) begin
      model_q.delete();
    end else begin
      n     = model_q.size();
      full  = (n == DEPTH);
      empty = (n == 0);
      if (clr_err) begin
        m_ovf = 0;
        m_udf = 0;
      end
      if (w_en && full && !r_en) m_ovf = 1;
      if (r_en && empty)         m_udf = 1;
      if (r_en && !empty)        void'(model_q.pop_front());
      if (w_en && (!full || r_en)) model_q.push_back(in_data);
    end
  endtask

  task automatic compare_all();
    int n = model_q.size();
    check("contain_num", 32'(contain_num), 32'(n));
    check("q_empty", 32'(q_empty), 32'(n == 0));
    check("q_full", 32'(q_full), 32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("udf", 32'(udf), 32'(m_udf));
    if (n > 0) check("out_data", 32'(out_data), 32'(model_q[0]));
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit r,
                     input bit f = 0, input bit c = 0, input bit rs = 0);
    w_en = w; in_data = d; r_en = r; flush = f; clr_err = c; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int k;
    logic [7:0] d;
    rst = 1; flush = 0; w_en = 0; r_en = 0; clr_err = 0; in_data = '0;

    // 1: reset
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_empty", 32'(q_empty), 32'd1);
    check("rst_count", 32'(contain_num), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);

    // 2: fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'h10 + 8'(i), 0);
      if (i == 4) check("af_before_6", 32'(almost_full), 32'd0);
      if (i == 5) check("af_after_6", 32'(almost_full), 32'd1);
    end
    check("fill_full", 32'(q_full), 32'd1);
    check("fill_count", 32'(contain_num), 32'd8);
    cyc(1, 8'hEE, 0);
    check("ovf_set", 32'(ovf), 32'd1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 32'(out_data), 32'h10 + 32'(i));
      cyc(0, 0, 1);
    end
    check("drain_empty", 32'(q_empty), 32'd1);

    // 3: full with simultaneous push/pop
    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0);
    check("sim_head", 32'(out_data), 32'h10);
    cyc(1, 8'hAA, 1);
    check("sim_count", 32'(contain_num), 32'd8);
    check("sim_no_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1);
    check("sim_last", 32'(out_data), 32'hAA);
    cyc(0, 0, 1);

    // 4: empty with simultaneous push/pop
    cyc(1, 8'h55, 1);
    check("emp_udf", 32'(udf), 32'd1);
    check("emp_count", 32'(contain_num), 32'd1);
    check("emp_data", 32'(out_data), 32'h55);
    cyc(0, 0, 1);

    // 5: alternating push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      if (model_q.size() == 0) cyc(1, 8'h80 + 8'(i), 0);
      else cyc(0, 0, 1);
      if (contain_num > 1) check("wrap_le1", 32'(contain_num), 32'd1);
    end
    cyc(0, 0, 0, 0, 1);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_udf", 32'(udf), 32'd0);

    // 6: flush at 5 with write, then reset at 3
    while (model_q.size() != 0) cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'h30 + 8'(i), 0);
    cyc(1, 8'h99, 0, 1);
    check("flush_count", 32'(contain_num), 32'd0);
    check("flush_empty", 32'(q_empty), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(i), 0);
    cyc(0, 0, 1);
    cyc(1, 8'h77, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst2_count", 32'(contain_num), 32'd0);
    check("rst2_empty", 32'(q_empty), 32'd1);
    check("rst2_ovf", 32'(ovf), 32'd0);

    // randomized phases: write-heavy, read-heavy, balanced
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 80; i++) begin
        k = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 25 : 50;
        d = 8'($urandom);
        cyc($urandom_range(0, 99) < k, d, $urandom_range(0, 99) >= k,
            $urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 149) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
